// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and the
// default payload width. The Rx path imports the same package.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/parity_calc.sv
// Parity generator shared by the Tx serializer and the Rx parity checker.
// Even parity makes the total count of ones even; odd parity inverts that bit.
module parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one CLK period per bit, frame = start, data LSB first,
// optional parity, stop. TX_OUT and Busy are registered outputs.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (low) on the line
//   DATA   | data bit bit_cnt on the line, DATA_WIDTH cycles
//   PARITY | parity bit on the line (only when latched PAR_EN = 1)
//   STOP   | stop bit (high) on the line; Busy drops on leaving
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]   LAST_IDX = CW'(DATA_WIDTH - 1);

   uart_state_e           state;
   uart_state_e           state_nxt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [CW-1:0]         bit_cnt;
   logic [CW-1:0]         bit_cnt_nxt;
   logic                  par_bit;
   logic                  tx_nxt;
   logic                  busy_nxt;
   logic                  accept;
   logic                  last_bit;

   assign accept   = (state == IDLE) && Data_Valid;
   // bit_cnt holds the index of the data bit currently on the line
   assign last_bit = (bit_cnt == LAST_IDX);

   parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_calc (
      .data    (data_q),
      .par_typ (par_typ_q),
      .par_bit (par_bit)
   );

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Payload/config capture at acceptance and bit index counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Registered line outputs, so the line never glitches on state decode
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         TX_OUT <= 1'b1;
         Busy   <= 1'b0;
      end else begin
         TX_OUT <= tx_nxt;
         Busy   <= busy_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Data_Valid) state_nxt = START;
         START:   state_nxt = DATA;
         DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Serializer mux: value the line takes on the coming edge, plus counter step
   always_comb begin
      tx_nxt      = 1'b1;
      busy_nxt    = 1'b1;
      bit_cnt_nxt = bit_cnt;
      case (state)
         IDLE: begin
            tx_nxt      = ~Data_Valid;
            busy_nxt    = Data_Valid;
            bit_cnt_nxt = '0;
         end
         START: begin
            tx_nxt = data_q[0];
         end
         DATA: begin
            if (last_bit) begin
               tx_nxt      = par_en_q ? par_bit : 1'b1;
               bit_cnt_nxt = '0;
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
               tx_nxt      = data_q[bit_cnt_nxt];
            end
         end
         PARITY: begin
            tx_nxt = 1'b1;
         end
         STOP: begin
            busy_nxt = 1'b0;
         end
         default: begin
            busy_nxt    = 1'b0;
            bit_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames from the requirement list
// plus randomized traffic, all checked cycle by cycle against a frame-level model.
module tb_uart_tx;

   localparam int W = 8;

   logic         CLK        = 1'b0;
   logic         RST        = 1'b0;
   logic [W-1:0] P_DATA     = '0;
   logic         Data_Valid = 1'b0;
   logic         PAR_EN     = 1'b0;
   logic         PAR_TYP    = 1'b0;
   logic         TX_OUT;
   logic         Busy;

   int total = 0;
   int bad   = 0;

   // reference model: the whole frame as a list of line bits
   bit   fq[$];
   int   left     = 0;
   int   pos      = 0;
   logic exp_tx   = 1'b1;
   logic exp_busy = 1'b0;

   logic cap_tx[$];
   logic cap_busy[$];

   uart_tx #(.DATA_WIDTH(W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge
   task automatic model_edge();
      if (!RST) begin
         left = 0;
      end else if (left > 0) begin
         left--;
         pos++;
      end else if (Data_Valid) begin
         fq.delete();
         fq.push_back(1'b0);
         for (int i = 0; i < W; i++) fq.push_back(P_DATA[i]);
         if (PAR_EN) fq.push_back(bit'(($countones(P_DATA) % 2) ^ int'(PAR_TYP)));
         fq.push_back(1'b1);
         left = fq.size();
         pos  = 0;
      end
      exp_busy = (left > 0);
      exp_tx   = (left > 0) ? fq[pos] : 1'b1;
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("tx_out", 32'(TX_OUT), 32'(exp_tx));
      chk("busy", 32'(Busy), 32'(exp_busy));
      cap_tx.push_back(TX_OUT);
      cap_busy.push_back(Busy);
   endtask

   // line samples from index start, sample k placed at bit k
   function automatic logic [31:0] pack(input int start, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++)
         if (start + k < cap_tx.size()) v[k] = cap_tx[start + k];
      return v;
   endfunction

   function automatic int busy_cnt();
      int nb;
      nb = 0;
      foreach (cap_busy[i]) if (cap_busy[i] === 1'b1) nb++;
      return nb;
   endfunction

   task automatic clear_cap();
      cap_tx.delete();
      cap_busy.delete();
   endtask

   task automatic wait_idle(input string tag);
      for (int n = 0; n < 40 && Busy === 1'b1; n++) cycle();
      chk(tag, 32'(Busy), 32'd0);
   endtask

   // One pulsed request; inputs scrambled right after acceptance
   task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
      clear_cap();
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      cycle();
      Data_Valid = 1'b0;
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom_range(0, 1));
      PAR_TYP    = 1'($urandom_range(0, 1));
      wait_idle("frame_end");
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_tx", 32'(TX_OUT), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      RST = 1'b1;

      // basic frame, accepted on the first edge after reset release
      send(8'hA5, 1'b0, 1'b0);
      chk("a5_frame", pack(0, 10), 32'h34A);
      chk("a5_busy_len", 32'(busy_cnt()), 32'd10);

      // even parity
      send(8'h07, 1'b1, 1'b0);
      chk("p07_frame", pack(0, 11), 32'h60E);
      chk("p07_busy_len", 32'(busy_cnt()), 32'd11);

      // odd and even parity on all-ones
      send(8'hFF, 1'b1, 1'b1);
      chk("ff_odd_par", 32'(cap_tx[9]), 32'd1);
      send(8'hFF, 1'b1, 1'b0);
      chk("ff_even_par", 32'(cap_tx[9]), 32'd0);

      // back-to-back with Data_Valid held, payload changed mid-frame
      clear_cap();
      P_DATA     = 8'h3C;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      cycle();
      P_DATA = 8'hC3;
      repeat (11) cycle();
      chk("b2b_gap_busy", 32'(cap_busy[10]), 32'd0);
      chk("b2b_gap_tx", 32'(cap_tx[10]), 32'd1);
      chk("b2b_second_start", 32'(cap_busy[11]), 32'd1);
      Data_Valid = 1'b0;
      wait_idle("b2b_end");
      chk("b2b_first_data", pack(1, 8), 32'h3C);
      chk("b2b_second_data", pack(12, 8), 32'hC3);

      // request during DATA is ignored, nothing queued
      clear_cap();
      P_DATA     = 8'h0F;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      cycle();
      Data_Valid = 1'b0;
      repeat (3) cycle();
      P_DATA     = 8'h55;
      Data_Valid = 1'b1;
      cycle();
      Data_Valid = 1'b0;
      wait_idle("ign_end");
      repeat (5) cycle();
      chk("ign_frame", pack(0, 10), 32'h21E);
      chk("ign_busy_len", 32'(busy_cnt()), 32'd10);

      // reset while data bit 3 of 0x81 is on the line
      clear_cap();
      P_DATA     = 8'h81;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      cycle();
      Data_Valid = 1'b0;
      repeat (4) cycle();
      chk("pre_rst_bit3", 32'(TX_OUT), 32'd0);
      #2 RST = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(TX_OUT), 32'd1);
      chk("mid_rst_busy", 32'(Busy), 32'd0);
      cycle();
      RST = 1'b1;
      clear_cap();
      repeat (6) cycle();
      chk("post_rst_idle", 32'(busy_cnt()), 32'd0);
      chk("post_rst_line", pack(0, 6), 32'h3F);

      // randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         P_DATA     = W'($urandom);
         PAR_EN     = 1'($urandom_range(0, 1));
         PAR_TYP    = 1'($urandom_range(0, 1));
         Data_Valid = ($urandom_range(0, 3) != 0);
         RST        = ($urandom_range(0, 149) != 0);
         cycle();
      end
      RST        = 1'b1;
      Data_Valid = 1'b0;
      cycle();
      wait_idle("rand_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
